// File: rtl/fir_pkg.sv
// Shared constants, coefficient table and state type for the folded 21-tap FIR.
package fir_pkg;

    localparam int WORD_SIZE = 10;
    localparam int TAP       = 21;
    localparam int COEF_W    = 6;
    localparam int ACC_W     = 21;
    localparam int OUT_W     = 12;
    localparam int TAP_W     = $clog2(TAP);
    localparam int PROD_W    = WORD_SIZE + COEF_W;

    typedef logic [TAP_W-1:0] tap_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_e;

    localparam tap_idx_t LAST_TAP = tap_idx_t'(TAP - 1);

    // Symmetric low-pass taps, DC gain 71.
    localparam logic signed [COEF_W-1:0] COEF [TAP] = '{
        -6'sd1,  6'sd1,  6'sd3,  6'sd2, -6'sd1, -6'sd4, -6'sd4,
         6'sd1,  6'sd10, 6'sd18, 6'sd21, 6'sd18, 6'sd10, 6'sd1,
        -6'sd4, -6'sd4, -6'sd1,  6'sd2,  6'sd3,  6'sd1, -6'sd1
    };

    function automatic tap_idx_t rd_addr(input tap_idx_t cur, input tap_idx_t tap);
        logic [TAP_W:0] sum;
        if (cur >= tap) begin
            sum = {1'b0, cur} - {1'b0, tap};
        end else begin
            sum = {1'b0, cur} + (TAP_W+1)'(TAP) - {1'b0, tap};
        end
        return sum[TAP_W-1:0];
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed multiplier and accumulator for the folded FIR datapath.
module fir_mac_unit
    import fir_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [WORD_SIZE-1:0] sample_i,
    input  logic signed [COEF_W-1:0]    coef_i,
    input  logic                        clear_i,
    input  logic                        enable_i,
    output logic signed [ACC_W-1:0]     acc_next_o
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    assign prod     = sample_i * coef_i;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign acc_d    = acc_q + prod_ext;

    assign acc_next_o = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (enable_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fir_fold_sched.sv
// Folded 21-tap FIR controller: circular sample buffer, tap sequencer and handshakes.
// state | meaning
// IDLE  | waiting for a sample, in_ready high
// MAC   | one tap per cycle, 21 cycles
// DONE  | result held on out_data until out_ready
module fir_fold_sched
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 busy
);

    fir_state_e state_q, state_d;

    logic signed [WORD_SIZE-1:0] sbuf_q [TAP];
    tap_idx_t wr_ptr_q, wr_ptr_d;
    tap_idx_t cur_q, cur_d;
    tap_idx_t tap_q, tap_d;
    tap_idx_t rd_ptr;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;

    logic accept;
    logic mac_clear;
    logic mac_en;
    logic signed [ACC_W-1:0] acc_next;
    logic unused_acc_bits;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign accept    = in_valid && in_ready;
    assign rd_ptr    = rd_addr(cur_q, tap_q);

    assign unused_acc_bits = ^{acc_next[ACC_W-1:OUT_W], acc_next[0]};

    fir_mac_unit u_mac (
        .clk        (clk),
        .rst        (rst),
        .sample_i   (sbuf_q[rd_ptr]),
        .coef_i     (COEF[tap_q]),
        .clear_i    (mac_clear),
        .enable_i   (mac_en),
        .acc_next_o (acc_next)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cur_d       = cur_q;
        tap_d       = tap_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mac_clear   = 1'b0;
        mac_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cur_d     = wr_ptr_q;
                    wr_ptr_d  = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
                    tap_d     = '0;
                    mac_clear = 1'b1;
                    state_d   = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (tap_q == LAST_TAP) begin
                    // Truncate to bits [11:1]; the LSB is always reported as zero.
                    out_data_d  = {acc_next[OUT_W-1:1], 1'b0};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cur_q       <= '0;
            tap_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cur_q       <= cur_d;
            tap_q       <= tap_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAP; i++) begin
                sbuf_q[i] <= '0;
            end
        end else if (accept) begin
            sbuf_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
